// File: rtl/eater_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eater_pkg                                                        |
// | Shared widths, opcodes, bus-source encoding and control word.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package eater_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] LDA = 4'h1;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_PC   = 3'd1,
    SRC_RAM  = 3'd2,
    SRC_IR   = 3'd3,
    SRC_A    = 3'd4,
    SRC_ALU  = 3'd5
  } bus_src_e;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_t;

  // Highest-priority driver wins when the decoder asserts several at once.
  function automatic bus_src_e pick_src(input ctrl_t c);
    if (c.co)        return SRC_PC;
    else if (c.ro)   return SRC_RAM;
    else if (c.io)   return SRC_IR;
    else if (c.ao)   return SRC_A;
    else if (c.sumo) return SRC_ALU;
    else             return SRC_NONE;
  endfunction

  function automatic logic multi_drive(input ctrl_t c);
    logic [2:0] n;
    n = {2'b00, c.co} + {2'b00, c.ro} + {2'b00, c.io} + {2'b00, c.ao} + {2'b00, c.sumo};
    return (n > 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eater_ram16x8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eater_ram16x8                                                    |
// | Program/data RAM: async read, sync write, loader beats bus write.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module eater_ram16x8
  import eater_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [1<<ADDR_W];
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // A loader write on the same edge as a bus write drops the bus write entirely.
  always_comb begin
    w_we    = i_prog_we | i_bus_we;
    w_waddr = i_bus_addr;
    w_wdata = i_bus_data;
    if (i_prog_we) begin
      w_waddr = i_prog_addr;
      w_wdata = i_prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/eater_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eater_datapath                                                   |
// | Shared-bus register datapath of the 8-bit computer.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module eater_datapath
  import eater_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hlt,
  input  logic              i_mi,
  input  logic              i_ri,
  input  logic              i_ro,
  input  logic              i_io,
  input  logic              i_ii,
  input  logic              i_ai,
  input  logic              i_ao,
  input  logic              i_sumo,
  input  logic              i_sub,
  input  logic              i_bi,
  input  logic              i_oi,
  input  logic              i_ce,
  input  logic              i_co,
  input  logic              i_j,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [DATA_W-1:0] o_insn,
  output logic [DATA_W-1:0] o_out_val,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic              o_carry,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_bus_conflict
);

  ctrl_t             w_ctrl;
  bus_src_e          w_src;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_ram_rd;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_alu;
  logic              w_ld;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_halted;

  assign w_ctrl = {i_hlt, i_mi, i_ri, i_ro, i_io, i_ii, i_ai, i_ao,
                   i_sumo, i_sub, i_bi, i_oi, i_ce, i_co, i_j};
  assign w_src  = pick_src(w_ctrl);
  assign w_ld   = ~r_halted;

  // Subtract as a + ~b + 1 so the top bit reads as "no borrow".
  assign w_b_op = w_ctrl.sub ? ~r_b : r_b;
  assign w_alu  = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_ctrl.sub};

  always_comb begin
    w_bus = '0;
    case (w_src)
      SRC_PC:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
      SRC_RAM: w_bus = w_ram_rd;
      SRC_IR:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
      SRC_A:   w_bus = r_a;
      SRC_ALU: w_bus = w_alu[DATA_W-1:0];
      default: w_bus = '0;
    endcase
  end

  eater_ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk         (clk),
    .i_prog_we   (i_prog_we),
    .i_prog_addr (i_prog_addr),
    .i_prog_data (i_prog_data),
    .i_bus_we    (w_ld & w_ctrl.ri),
    .i_bus_addr  (r_mar),
    .i_bus_data  (w_bus),
    .i_rd_addr   (r_mar),
    .o_rd_data   (w_ram_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_halted    <= r_halted | w_ctrl.hlt;
      r_out_valid <= w_ld & w_ctrl.oi;
      if (w_ld) begin
        if (w_ctrl.mi) r_mar <= w_bus[ADDR_W-1:0];
        if (w_ctrl.ii) r_ir  <= w_bus;
        if (w_ctrl.ai) r_a   <= w_bus;
        if (w_ctrl.bi) r_b   <= w_bus;
        if (w_ctrl.oi) r_out <= w_bus;
        if (w_ctrl.j)       r_pc <= w_bus[ADDR_W-1:0];
        else if (w_ctrl.ce) r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign o_insn         = r_ir;
  assign o_out_val      = r_out;
  assign o_out_valid    = r_out_valid;
  assign o_halted       = r_halted;
  assign o_carry        = w_alu[DATA_W];
  assign o_bus          = w_bus;
  assign o_bus_conflict = multi_drive(w_ctrl);

endmodule
`default_nettype wire

// File: tb/tb_eater_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_eater_datapath                                                |
// | Directed stimulus with an arithmetic reference model.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_eater_datapath;

  localparam logic [14:0] C_HLT  = 15'h4000;
  localparam logic [14:0] C_MI   = 15'h2000;
  localparam logic [14:0] C_RI   = 15'h1000;
  localparam logic [14:0] C_RO   = 15'h0800;
  localparam logic [14:0] C_IO   = 15'h0400;
  localparam logic [14:0] C_II   = 15'h0200;
  localparam logic [14:0] C_AI   = 15'h0100;
  localparam logic [14:0] C_AO   = 15'h0080;
  localparam logic [14:0] C_SUMO = 15'h0040;
  localparam logic [14:0] C_SUB  = 15'h0020;
  localparam logic [14:0] C_BI   = 15'h0010;
  localparam logic [14:0] C_OI   = 15'h0008;
  localparam logic [14:0] C_CE   = 15'h0004;
  localparam logic [14:0] C_CO   = 15'h0002;
  localparam logic [14:0] C_J    = 15'h0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] ctl = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  pa = '0;
  logic [7:0]  pd = '0;

  logic [7:0] o_insn, o_out_val, o_bus;
  logic       o_out_valid, o_halted, o_carry, o_bus_conflict;

  int total = 0;
  int bad   = 0;
  int npulse = 0;

  always #5 clk = ~clk;

  eater_datapath dut (
    .clk(clk), .rst(rst),
    .i_hlt(ctl[14]), .i_mi(ctl[13]), .i_ri(ctl[12]), .i_ro(ctl[11]),
    .i_io(ctl[10]), .i_ii(ctl[9]), .i_ai(ctl[8]), .i_ao(ctl[7]),
    .i_sumo(ctl[6]), .i_sub(ctl[5]), .i_bi(ctl[4]), .i_oi(ctl[3]),
    .i_ce(ctl[2]), .i_co(ctl[1]), .i_j(ctl[0]),
    .i_prog_we(prog_we), .i_prog_addr(pa), .i_prog_data(pd),
    .o_insn(o_insn), .o_out_val(o_out_val), .o_out_valid(o_out_valid),
    .o_halted(o_halted), .o_carry(o_carry), .o_bus(o_bus),
    .o_bus_conflict(o_bus_conflict)
  );

  // Reference model state
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic       m_valid, m_halt;
  logic [7:0] m_mem [16];

  function automatic bit has(input logic [14:0] m);
    return (ctl & m) != 15'h0;
  endfunction

  function automatic logic [8:0] m_alu();
    int s;
    if (has(C_SUB)) s = int'(m_a) + 256 - int'(m_b);
    else            s = int'(m_a) + int'(m_b);
    return s[8:0];
  endfunction

  function automatic logic [7:0] m_bus();
    logic [8:0] r;
    r = m_alu();
    if (has(C_CO))   return {4'h0, m_pc};
    if (has(C_RO))   return m_mem[m_mar];
    if (has(C_IO))   return {4'h0, m_ir[3:0]};
    if (has(C_AO))   return m_a;
    if (has(C_SUMO)) return r[7:0];
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_bus4();
    logic [7:0] v;
    v = m_bus();
    return v[3:0];
  endfunction

  function automatic logic m_carry();
    logic [8:0] r;
    r = m_alu();
    return r[8];
  endfunction

  function automatic logic m_conf();
    int n;
    n = int'(has(C_CO)) + int'(has(C_RO)) + int'(has(C_IO)) + int'(has(C_AO)) + int'(has(C_SUMO));
    return n > 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= '0; m_mar <= '0; m_ir <= '0; m_a <= '0; m_b <= '0;
      m_out <= '0; m_valid <= 1'b0; m_halt <= 1'b0;
    end else begin
      if (prog_we) m_mem[pa] <= pd;
      else if (has(C_RI) && !m_halt) m_mem[m_mar] <= m_bus();
      m_valid <= !m_halt && has(C_OI);
      if (has(C_HLT)) m_halt <= 1'b1;
      if (!m_halt) begin
        if (has(C_MI)) m_mar <= m_bus4();
        if (has(C_II)) m_ir  <= m_bus();
        if (has(C_AI)) m_a   <= m_bus();
        if (has(C_BI)) m_b   <= m_bus();
        if (has(C_OI)) m_out <= m_bus();
        if (has(C_J))       m_pc <= m_bus4();
        else if (has(C_CE)) m_pc <= 4'((int'(m_pc) + 1) % 16);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    chk("bus", o_bus, m_bus());
    chk("bus_conflict", {7'h0, o_bus_conflict}, {7'h0, m_conf()});
    chk("carry", {7'h0, o_carry}, {7'h0, m_carry()});
    chk("insn", o_insn, m_ir);
    chk("out_val", o_out_val, m_out);
    chk("out_valid", {7'h0, o_out_valid}, {7'h0, m_valid});
    chk("halted", {7'h0, o_halted}, {7'h0, m_halt});
    if (o_out_valid === 1'b1) npulse++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input logic [14:0] c);
    ctl = c;
    tick();
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d, input logic [14:0] c);
    ctl = c; prog_we = 1'b1; pa = a; pd = d;
    tick();
    prog_we = 1'b0; ctl = '0;
  endtask

  // Put a value on the bus through RAM at the current MAR, then load it.
  task automatic via_ram(input logic [7:0] v, input logic [14:0] ld);
    prog(m_mar, v, '0);
    cyc(C_RO | ld);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    chk("rst insn", o_insn, 8'h00);
    chk("rst out_val", o_out_val, 8'h00);
    chk("rst halted", {7'h0, o_halted}, 8'h00);
    chk("rst out_valid", {7'h0, o_out_valid}, 8'h00);
    chk("rst bus", o_bus, 8'h00);

    // Program: LDA 14; ADD 15; OUT; HLT with 28 + 14
    prog(4'd0, 8'h1E, '0); prog(4'd1, 8'h2F, '0);
    prog(4'd2, 8'hE0, '0); prog(4'd3, 8'hF0, '0);
    prog(4'd14, 8'd28, '0); prog(4'd15, 8'd14, '0);
    npulse = 0;
    cyc(C_CO | C_MI); cyc(C_RO | C_II | C_CE); cyc(C_IO | C_MI); cyc(C_RO | C_AI);
    cyc(C_CO | C_MI); cyc(C_RO | C_II | C_CE); cyc(C_IO | C_MI); cyc(C_RO | C_BI);
    cyc(C_SUMO | C_AI);
    cyc(C_CO | C_MI); cyc(C_RO | C_II | C_CE); cyc(C_AO | C_OI);
    cyc(C_CO | C_MI); cyc(C_RO | C_II | C_CE); cyc(C_HLT);
    cyc(C_CO | C_MI); cyc(C_RO | C_II | C_CE);
    chk("prog out_val", o_out_val, 8'd42);
    chk("prog pulses", 8'(npulse), 8'd1);
    chk("prog halted", {7'h0, o_halted}, 8'h01);
    chk("prog insn", o_insn, 8'hF0);
    ctl = C_CO; #2;
    chk("halt pc frozen", o_bus, 8'h04);
    tick();

    // Loader works while halted; the concurrent bus load into A is ignored
    prog(4'd3, 8'h77, C_AI | C_RO);
    ctl = C_RO; #2; chk("halt prog write", o_bus, 8'h77); tick();
    ctl = C_AO; #2; chk("halt ai ignored", o_bus, 8'd42); tick();

    // Asynchronous reset in the middle of a cycle
    rst = 1'b1; tick(); rst = 1'b0; ctl = '0;
    via_ram(8'h55, C_AI | C_OI);
    via_ram(8'h07, C_J | C_II);
    cyc(C_HLT);
    ctl = C_CO | C_AO; #2;
    chk("pre-rst bus", o_bus, 8'h07);
    chk("pre-rst halted", {7'h0, o_halted}, 8'h01);
    rst = 1'b1; #1;
    chk("async rst insn", o_insn, 8'h00);
    chk("async rst out_val", o_out_val, 8'h00);
    chk("async rst halted", {7'h0, o_halted}, 8'h00);
    chk("async rst bus", o_bus, 8'h00);
    tick(); rst = 1'b0; ctl = '0;

    // ALU: 5 - 7 and 200 + 100
    via_ram(8'd5, C_AI); via_ram(8'd7, C_BI);
    ctl = C_SUMO | C_SUB | C_AI; #2;
    chk("sub carry", {7'h0, o_carry}, 8'h00);
    chk("sub bus", o_bus, 8'hFE);
    tick();
    ctl = C_AO; #2; chk("sub a", o_bus, 8'hFE); tick();
    via_ram(8'd200, C_AI); via_ram(8'd100, C_BI);
    ctl = C_SUMO; #2;
    chk("add bus", o_bus, 8'h2C);
    chk("add carry", {7'h0, o_carry}, 8'h01);
    ctl = C_SUMO | C_SUB; #2;
    chk("sub ge bus", o_bus, 8'd100);
    chk("sub ge carry", {7'h0, o_carry}, 8'h01);
    tick();

    // PC wrap and jump-over-increment
    via_ram(8'h0F, C_J);
    cyc(C_CE);
    ctl = C_CO; #2; chk("pc wrap", o_bus, 8'h00); tick();
    via_ram(8'h39, C_II);
    chk("ir 39", o_insn, 8'h39);
    cyc(C_IO | C_J | C_CE);
    ctl = C_CO; #2; chk("pc jump", o_bus, 8'h09); tick();

    // Bus conflict: PC beats RAM
    via_ram(8'h03, C_J);
    prog(m_mar, 8'hAA, '0);
    ctl = C_CO | C_RO | C_AI; #2;
    chk("conflict bus", o_bus, 8'h03);
    chk("conflict flag", {7'h0, o_bus_conflict}, 8'h01);
    tick();
    ctl = C_AO; #2;
    chk("conflict a", o_bus, 8'h03);
    chk("no conflict", {7'h0, o_bus_conflict}, 8'h00);
    tick();

    // Loader beats bus write on the same edge
    via_ram(8'h05, C_MI);
    via_ram(8'h22, C_AI);
    prog(4'd5, 8'h11, C_AO | C_RI);
    ctl = C_RO; #2; chk("loader wins", o_bus, 8'h11); tick();
    cyc(C_AO | C_RI);
    ctl = C_RO; #2; chk("bus write", o_bus, 8'h22); tick();
    cyc('0); cyc('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
